// File: rtl/floppy_timer_sched_if.sv
// rtl/floppy_timer_sched_if.sv - peripheral bus bundle for the floppy timer scheduler
// Purpose: groups the CPU-side register bus of floppy_timer_sched.
// Signals: addr (register select), di (write data), wren (single-cycle write
// strobe), q (read data, combinational from addr).
// Modports: master = CPU side, slave = timer block side.
interface floppy_timer_sched_if;
    logic [2:0] addr;
    logic [7:0] di;
    logic       wren;
    logic [7:0] q;

    modport master (output addr, output di, output wren, input q);
    modport slave  (input addr, input di, input wren, output q);
endinterface

// File: rtl/floppy_timer_sched.sv
// rtl/floppy_timer_sched.sv - four-channel 8-bit countdown timer scheduler with shared prescaler
// Purpose: a prescaler produces a tick every DIV = MCLKFREQ/TICKHZ clocks; each
// tick launches a 4-cycle sweep that decrements one channel per clock and
// latches expiry flags, which raise a maskable registered interrupt.
// Ports:
//   clk     - master clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - register bus (addr, di, wren in; q out)
//   irq     - registered |(flags & mask)
//   tick    - one-cycle pulse at each prescaler wrap
// Register map: 0-3 CNT0..3, 4 STATUS (W1C), 5 MASK, 6 PEND (RO), 7 reads 0.
module floppy_timer_sched #(
    parameter int unsigned MCLKFREQ = 24000000,
    parameter int unsigned TICKHZ   = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    floppy_timer_sched_if.slave  bus,
    output logic                 irq,
    output logic                 tick
);
    localparam int unsigned DIV    = MCLKFREQ / TICKHZ;
    localparam logic [23:0] RELOAD = 24'(DIV - 1);

    // A sweep lasts 4 clocks; DIV >= 8 guarantees no tick lands inside one.
    generate
        if (DIV < 8) begin : g_div_check
            $error("floppy_timer_sched: MCLKFREQ/TICKHZ must be >= 8");
        end
    endgenerate

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] presc_q, presc_d;
    logic        tick_q, tick_d;
    logic [7:0]  cnt_q [4];
    logic [7:0]  cnt_d [4];
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  mask_q, mask_d;
    logic        irq_q, irq_d;

    logic [3:0]  set_v;
    logic [3:0]  clr_v;
    logic        cpu_hits_idx;

    always_comb begin
        presc_d      = (presc_q == 24'd0) ? RELOAD : presc_q - 24'd1;
        tick_d       = (presc_q == 24'd0);
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        set_v        = 4'b0000;
        clr_v        = 4'b0000;
        cpu_hits_idx = bus.wren && (bus.addr == {1'b0, idx_q});

        case (state_q)
            ST_IDLE: begin
                if (tick_q) begin
                    state_d = ST_SCAN;
                    idx_d   = 2'd0;
                end
            end
            ST_SCAN: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
                // A CPU load of the channel being serviced suppresses its decrement.
                if (!cpu_hits_idx && (cnt_q[idx_q] != 8'd0)) begin
                    cnt_d[idx_q] = cnt_q[idx_q] - 8'd1;
                    if (cnt_q[idx_q] == 8'd1) begin
                        set_v[idx_q] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.wren) begin
            case (bus.addr)
                3'd0, 3'd1, 3'd2, 3'd3: cnt_d[bus.addr[1:0]] = bus.di;
                3'd4:                   clr_v  = bus.di[3:0];
                3'd5:                   mask_d = bus.di[3:0];
                default: ;
            endcase
        end

        // Set takes priority over a same-cycle write-1-to-clear.
        flags_d = (flags_q & ~clr_v) | set_v;
        irq_d   = |(flags_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            presc_q <= RELOAD;
            tick_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
            flags_q <= 4'b0000;
            mask_q  <= 4'b0000;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            flags_q <= flags_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        case (bus.addr)
            3'd0, 3'd1, 3'd2, 3'd3: bus.q = cnt_q[bus.addr[1:0]];
            3'd4:                   bus.q = {4'b0000, flags_q};
            3'd5:                   bus.q = {4'b0000, mask_q};
            3'd6:                   bus.q = {4'b0000, flags_q & mask_q};
            default:                bus.q = 8'h00;
        endcase
    end

    assign irq  = irq_q;
    assign tick = tick_q;
endmodule

// File: tb/tb_floppy_timer_sched.sv
// tb/tb_floppy_timer_sched.sv - randomized and directed check of floppy_timer_sched against a behavioural model
module tb_floppy_timer_sched;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic irq;
    logic tick;

    floppy_timer_sched_if bus();

    floppy_timer_sched #(.MCLKFREQ(1000), .TICKHZ(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .irq     (irq),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: edges counted since reset release; a tick follows every DIV-th
    // edge and channel i is serviced on the edge two plus i clocks after it.
    int         m_n;
    logic [7:0] m_cnt [4];
    logic [3:0] m_flags;
    logic [3:0] m_mask;
    logic       m_irq;
    logic       m_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_cnt[a[1:0]];
            3'd4:                   return {4'b0000, m_flags};
            3'd5:                   return {4'b0000, m_mask};
            3'd6:                   return {4'b0000, m_flags & m_mask};
            default:                return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
        m_flags = 4'b0000;
        m_mask  = 4'b0000;
        m_irq   = 1'b0;
        m_tick  = 1'b0;
        m_n     = 0;
    endtask

    task automatic m_edge(input logic wr, input logic [2:0] a, input logic [7:0] d);
        logic [3:0] set_bits;
        logic       next_irq;
        set_bits = 4'b0000;
        m_n++;
        next_irq = |(m_flags & m_mask);
        for (int i = 0; i < 4; i++) begin
            if (m_n >= DIV && (m_n % DIV) == 2 + i) begin
                if (!(wr && int'(a) == i) && m_cnt[i] != 8'd0) begin
                    if (m_cnt[i] == 8'd1) set_bits[i] = 1'b1;
                    m_cnt[i] = m_cnt[i] - 8'd1;
                end
            end
        end
        if (wr) begin
            if (a < 3'd4)       m_cnt[a[1:0]] = d;
            else if (a == 3'd4) m_flags = m_flags & ~d[3:0];
            else if (a == 3'd5) m_mask = d[3:0];
        end
        m_flags = m_flags | set_bits;
        m_irq   = next_irq;
        m_tick  = ((m_n % DIV) == 0);
    endtask

    task automatic step(input logic wr, input logic [2:0] a, input logic [7:0] d);
        bus.wren = wr;
        bus.addr = a;
        bus.di   = d;
        @(posedge clk);
        m_edge(wr, a, d);
        #1;
        chk($sformatf("tick@%0d", m_n), tick, m_tick);
        chk($sformatf("irq@%0d", m_n), irq, m_irq);
        chk($sformatf("q[%0d]@%0d", a, m_n), bus.q, m_read(a));
        bus.wren = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(1'b0, 3'(j), 8'h00);
    endtask

    // Idle until the next clock edge is the given phase within the tick period.
    task automatic wait_phase(input int p);
        for (int j = 0; j < 2 * DIV; j++) begin
            if (((m_n + 1) % DIV) == p && (m_n + 1) >= DIV) return;
            step(1'b0, 3'($urandom), 8'h00);
        end
    endtask

    // Reads all eight registers within one clock phase (starts just after an edge).
    task automatic read_all(input string tag);
        for (int a = 0; a < 8; a++) begin
            bus.addr = 3'(a);
            #1;
            chk($sformatf("%s q[%0d]", tag, a), bus.q, m_read(3'(a)));
        end
    endtask

    initial begin
        bus.wren = 1'b0;
        bus.addr = 3'd0;
        bus.di   = 8'h00;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset tick", tick, 1'b0);
        chk("reset irq", irq, 1'b0);
        read_all("reset");
        reset_n = 1'b1;

        // Idle: ticks at 10 and 20 after release, all registers zero.
        idle(25);

        // CNT0 = 3 with CH0 unmasked: expires on the third sweep.
        step(1'b1, 3'd0, 8'd3);
        step(1'b1, 3'd5, 8'h01);
        idle(40);

        // W1C with zero is a no-op, then clear bit 0.
        step(1'b1, 3'd4, 8'h00);
        step(1'b1, 3'd4, 8'h01);
        idle(3);

        // Mixed counts: 1 expires, 0 holds without wrap, 255 decrements.
        step(1'b1, 3'd0, 8'd1);
        step(1'b1, 3'd1, 8'd2);
        step(1'b1, 3'd2, 8'd0);
        step(1'b1, 3'd3, 8'd255);
        idle(DIV + 2);
        read_all("sweep");
        idle(1);

        // CPU load of CNT2 exactly in its service cycle.
        step(1'b1, 3'd0, 8'd9);
        step(1'b1, 3'd1, 8'd9);
        step(1'b1, 3'd3, 8'd9);
        wait_phase(4);
        step(1'b1, 3'd2, 8'd5);
        idle(3);

        // Expiry of CH1 collides with a W1C of bit 1: set wins.
        step(1'b1, 3'd1, 8'd1);
        step(1'b1, 3'd5, 8'h0f);
        wait_phase(3);
        step(1'b1, 3'd4, 8'h02);
        idle(3);

        // Reset in the middle of a sweep.
        step(1'b1, 3'd3, 8'd7);
        step(1'b1, 3'd0, 8'd1);
        wait_phase(3);
        step(1'b0, 3'd4, 8'h00);
        reset_n = 1'b0;
        m_reset();
        read_all("midreset");
        repeat (2) @(posedge clk);
        #1;
        chk("midreset tick", tick, 1'b0);
        chk("midreset irq", irq, 1'b0);
        reset_n = 1'b1;
        idle(25);

        // Random traffic; counts kept small so expiries happen often.
        for (int j = 0; j < 400; j++) begin
            logic       wr;
            logic [2:0] a;
            logic [7:0] d;
            wr = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom);
            d  = 8'($urandom);
            if (a < 3'd4 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 3));
            step(wr, a, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
